// File: rtl/hazard_scoreboard_pkg.sv
// Shared opcode constants, in-flight entry layout and opcode class helpers
// for the decode-side hazard scoreboard.
package hazard_scoreboard_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   function automatic logic writes_rd(input logic [6:0] op);
      return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR) ||
             (op == OP_LOAD) || (op == OP_IMM) || (op == OP_REG);
   endfunction

   function automatic logic reads_rs1(input logic [6:0] op);
      return (op == OP_JALR) || (op == OP_BRANCH) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_IMM) || (op == OP_REG);
   endfunction

   function automatic logic reads_rs2(input logic [6:0] op);
      return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_REG);
   endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Youngest-first producer search for one decode source operand.
// Latency: combinational; returns sel = 0 when the winning producer is a not-yet-ready load.
module hazard_src_match
   import hazard_scoreboard_pkg::*;
#(
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int SELW       = $clog2(DEPTH + 1)
) (
   input  logic [DEPTH*ENTRY_W-1:0] i_ents,
   input  logic                     i_req,
   input  logic [4:0]               i_rs,
   output logic                     o_stall,
   output logic [SELW-1:0]          o_sel
);

   entry_t [DEPTH:1] w_ents;
   logic             w_hit_ld;
   logic [SELW-1:0]  w_sel;

   assign w_ents = i_ents;

   // Scan oldest to youngest so the last (lowest-index) match overrides.
   always_comb begin
      w_hit_ld = 1'b0;
      w_sel    = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (i_req && (i_rs != 5'd0) && w_ents[k].valid && w_ents[k].wr &&
             (w_ents[k].rd == i_rs)) begin
            w_sel    = SELW'(k);
            w_hit_ld = w_ents[k].ld && (k < LOAD_STAGE);
         end
      end
   end

   assign o_stall = w_hit_ld;
   assign o_sel   = w_hit_ld ? '0 : w_sel;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard/forwarding scoreboard: DEPTH-entry shift of in-flight rd, combinational stall/forward selects.
// Latency: outputs same-cycle, state updates at posedge; mem_wait freezes all entries. Optional HAZARD_PERF_CNT_EN adds stall_cnt.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int SELW       = $clog2(DEPTH + 1)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_id_valid,
   input  logic [6:0]      i_id_op,
   input  logic [4:0]      i_id_rs1,
   input  logic [4:0]      i_id_rs2,
   input  logic [4:0]      i_id_rd,
   input  logic            i_mem_wait,
   input  logic            i_flush,
   output logic            o_hz_stall,
   output logic [SELW-1:0] o_fwd_sel1,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]     o_stall_cnt,
`endif
   output logic [SELW-1:0] o_fwd_sel2
);

   entry_t [DEPTH:1]         r_ents;
   logic                     r_flush_pend;
   logic [DEPTH*ENTRY_W-1:0] w_ents_flat;
   logic                     w_stall1;
   logic                     w_stall2;
   logic                     w_flush_eff;
   logic                     w_advance;
   entry_t                   w_new;

   assign w_ents_flat = r_ents;
   assign w_flush_eff = i_flush | r_flush_pend;
   assign w_advance   = ~i_mem_wait;
   assign o_hz_stall  = (w_stall1 | w_stall2) & ~w_flush_eff;

   hazard_src_match #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SELW(SELW)) u_match_rs1 (
      .i_ents  (w_ents_flat),
      .i_req   (i_id_valid & reads_rs1(i_id_op)),
      .i_rs    (i_id_rs1),
      .o_stall (w_stall1),
      .o_sel   (o_fwd_sel1)
   );

   hazard_src_match #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SELW(SELW)) u_match_rs2 (
      .i_ents  (w_ents_flat),
      .i_req   (i_id_valid & reads_rs2(i_id_op)),
      .i_rs    (i_id_rs2),
      .o_stall (w_stall2),
      .o_sel   (o_fwd_sel2)
   );

   always_comb begin
      w_new       = '0;
      w_new.valid = i_id_valid & ~o_hz_stall & ~w_flush_eff;
      w_new.rd    = i_id_rd;
      w_new.wr    = writes_rd(i_id_op);
      w_new.ld    = (i_id_op == OP_LOAD);
      if (!w_new.valid) w_new = '0;
   end

   // A flush arriving during a freeze is remembered so the killed decode slot
   // becomes the bubble on the first advancing edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ents       <= '0;
         r_flush_pend <= 1'b0;
      end else if (w_advance) begin
         for (int k = DEPTH; k >= 2; k--) r_ents[k] <= r_ents[k-1];
         r_ents[1]    <= w_new;
         r_flush_pend <= 1'b0;
      end else if (i_flush) begin
         r_flush_pend <= 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
      end else if (o_hz_stall && w_advance && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [6:0] id_op;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       mem_wait, flush;
   logic       hz_stall;
   logic [1:0] fwd_sel1, fwd_sel2;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   hazard_scoreboard #(.DEPTH(3), .LOAD_STAGE(2)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_id_valid (id_valid),
      .i_id_op    (id_op),
      .i_id_rs1   (id_rs1),
      .i_id_rs2   (id_rs2),
      .i_id_rd    (id_rd),
      .i_mem_wait (mem_wait),
      .i_flush    (flush),
      .o_hz_stall (hz_stall),
      .o_fwd_sel1 (fwd_sel1),
`ifdef HAZARD_PERF_CNT_EN
      .o_stall_cnt(stall_cnt),
`endif
      .o_fwd_sel2 (fwd_sel2)
   );

   typedef struct packed {
      logic        hz;
      logic [1:0]  s1;
      logic [1:0]  s2;
      logic [31:0] cnt;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;
   int    stall_total = 0;

   // Expected stall count seen at a sample is the number of earlier stall edges.
   task automatic step(input string nm, input logic v, input logic [6:0] op,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mw, input logic fl, input logic r, input logic chk,
                       input logic hz, input logic [1:0] s1, input logic [1:0] s2);
      exp_t e;
      @(posedge clk);
      #1;
      id_valid = v; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      mem_wait = mw; flush = fl; rst = r;
      if (chk) begin
         e.hz = hz; e.s1 = s1; e.s2 = s2; e.cnt = 32'(stall_total);
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
      if (r) stall_total = 0;
      else if (hz && !mw) stall_total++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step("idle", 1'b0, OP_REG, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         checks++;
         if (hz_stall !== e.hz) begin
            errors++;
            $display("FAIL %s hz_stall got %0b want %0b", nm, hz_stall, e.hz);
         end
         checks++;
         if (fwd_sel1 !== e.s1) begin
            errors++;
            $display("FAIL %s fwd_sel1 got %0d want %0d", nm, fwd_sel1, e.s1);
         end
         checks++;
         if (fwd_sel2 !== e.s2) begin
            errors++;
            $display("FAIL %s fwd_sel2 got %0d want %0d", nm, fwd_sel2, e.s2);
         end
`ifdef HAZARD_PERF_CNT_EN
         checks++;
         if (stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, e.cnt);
         end
`endif
      end
   end

   initial begin
      rst = 1'b1; id_valid = 1'b0; id_op = OP_REG; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      mem_wait = 1'b0; flush = 1'b0;

      step("reset", 1'b0, OP_REG, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
      step("reset", 1'b1, OP_REG, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);

      // EX forward and youngest-producer priority.
      step("add_x1",    1'b1, OP_REG, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      step("fwd_ex",    1'b1, OP_REG, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0);
      step("add_x1b",   1'b1, OP_REG, 5'd4, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      step("youngest",  1'b1, OP_REG, 5'd1, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2);
      idle(3);

      // Load-use: one stall, then forward from entry 2 and 3.
      step("lw_x5",     1'b1, OP_LOAD, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      step("lu_stall",  1'b1, OP_REG, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
      step("lu_fwd",    1'b1, OP_REG, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd2);
      step("lu_wb",     1'b1, OP_REG, 5'd6, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd3);
      idle(3);

      // Load-use held across a 3-cycle freeze.
      step("lw_x5_mw",  1'b1, OP_LOAD, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      for (int i = 0; i < 3; i++)
         step("mw_hold", 1'b1, OP_REG, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
      step("mw_stall",  1'b1, OP_REG, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
      step("mw_fwd",    1'b1, OP_REG, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0);
      idle(3);

      // Flush during freeze: x7 never recorded, stall suppressed.
      step("lw_x5_fl",  1'b1, OP_LOAD, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      step("fl_mw",     1'b1, OP_REG, 5'd5, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      step("fl_pend",   1'b1, OP_REG, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      step("fl_release",1'b1, OP_REG, 5'd5, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      step("fl_no_x7",  1'b1, OP_REG, 5'd7, 5'd5, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2);
      idle(3);

      // x0 never matches; opcode class gating of rs2.
      step("addi_x0",   1'b1, OP_IMM,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      step("lw_x0",     1'b1, OP_LOAD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      step("rd_x0",     1'b1, OP_REG,  5'd0, 5'd0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      idle(3);
      step("lw_x12",    1'b1, OP_LOAD, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      step("imm_no_rs2",1'b1, OP_IMM,  5'd0, 5'd12, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      idle(3);
      step("lw_x12b",   1'b1, OP_LOAD, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      step("sw_stall",  1'b1, OP_STORE,5'd0, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
      step("sw_fwd",    1'b1, OP_STORE,5'd0, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2);
      idle(3);

      // Reset during a freeze still clears the entries.
      step("lw_x5_rst", 1'b1, OP_LOAD, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      step("rst_mw",    1'b0, OP_REG, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
      step("after_rst", 1'b1, OP_REG, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);

      @(posedge clk);
      #1;
      id_valid = 1'b0;
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding scoreboard for the RV32I pipeline, sitting beside the decode stage. It holds a DEPTH-entry shift register of in-flight destination registers, one entry per stage past decode. Each cycle it resolves, for both decode source operands, which stage to forward from, or whether decode must stall for a load result. Youngest-producer priority replaces fixed pairwise conflict rules, and the block handles any pipeline depth, multi-cycle memory freezes and branch flushes.

## Interface
- DEPTH, 3: tracked stages past decode; entry 1 = EX, 2 = MEM, 3 = WB.
- LOAD_STAGE, 2: first entry index whose load result is forwardable; 2 ≤ LOAD_STAGE ≤ DEPTH.
- SELW, $clog2(DEPTH+1): width of forward selects.
- clk  in  1  pipeline clock.
- rst  in  1  reset; synchronous, active-high.
- id_valid  in  1  decode slot holds a valid instruction.
- id_op  in  7  decode opcode.
- id_rs1, id_rs2  in  5  decode source registers.
- id_rd  in  5  decode destination register.
- mem_wait  in  1  whole-pipe freeze from the memory stage.
- flush  in  1  taken branch or jump; the decode instruction is killed.
- hz_stall  out  1  decode must hold; a bubble enters EX.
- fwd_sel1, fwd_sel2  out  SELW  0 = register file; k = forward from entry k.
- stall_cnt  out  32  load-use stall cycles (only with the macro; see Configuration).

## Operation
- Entry fields: valid, rd, wr (opcode writes rd), ld (opcode is LOAD).
- Opcode classes:
  - Writes rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - Reads rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Reads rs2: BRANCH, STORE, OP.
- Match for source s:
  - Conditions: id_valid, opcode reads s, s ≠ x0, entry valid & wr & rd == s.
  - If several entries match, the lowest index (youngest) wins.
- Per source:
  - No match: sel = 0.
  - Winning entry k is a load with k < LOAD_STAGE: load-use hazard on that source; sel = 0.
  - Otherwise: sel = k.
- hz_stall = (load-use on rs1 or rs2) & !flush_eff.
- flush_eff = flush | flush_pend.
- advance = !mem_wait. On advance:
  - Entries k = 2..DEPTH take entry k-1.
  - Entry 1 takes the decode instruction if id_valid & !hz_stall & !flush_eff; otherwise a bubble (valid = 0).
- When mem_wait is high: all entries hold. A flush seen in this state sets flush_pend. flush_pend clears on the next advance, which inserts a bubble.
- Entries whose rd = x0 may be stored, but they never match.
- Reset clears all valid bits, flush_pend and stall_cnt. With no valid entries, hz_stall = 0 and fwd_sel1 = fwd_sel2 = 0.

## Timing
- hz_stall and fwd_sel* are combinational from the current inputs and entries, valid in the same cycle.
- The scoreboard updates at the rising edge of clk.
- Load-use with LOAD_STAGE = 2: exactly one stall cycle. The cycle after the stall, the select points at entry 2.
- A general load at entry k stalls for LOAD_STAGE − k advancing cycles.
- Cycles with mem_wait high do not consume stall cycles.
- rst asserted mid-operation takes effect at the next edge, regardless of mem_wait.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt port exists.
  - Increments on each edge where hz_stall & advance & !rst.
  - Saturates at 2^32 − 1.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- A shared package holds:
  - Opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG).
  - The entry struct type.
  - Class functions writes_rd, reads_rs1, reads_rs2.
- One sub-module, hazard_src_match, is instantiated twice (rs1, rs2). It takes the entry vector and a source register and returns {stall, sel} via a youngest-first priority scan.

## Test plan
- x1 = ADD in EX, decode ADD x3,x1,x2 → fwd_sel1 = 1, fwd_sel2 = 0, hz_stall = 0.
- x1 = ADD in EX and older ADD x1 in MEM, decode reads x1 → fwd_sel1 = 1 (youngest wins).
- LW x5 in EX, decode ADD x6,x5,x5 → hz_stall = 1 for one cycle. Next cycle fwd_sel1 = fwd_sel2 = 2; the bubble occupies entry 1.
- LW x5 in EX, mem_wait high for 3 cycles → hz_stall held at 1 and the entries frozen. After release, one stall cycle, then fwd_sel1 = 2.
- flush during mem_wait while decode holds ADD x7 → after release entry 1 is a bubble and x7 is never recorded.
- Producer writes x0, decode reads x0 → sel = 0 and no stall. With the macro defined, stall_cnt counts 1 per load-use stall and 0 for mem_wait-only cycles.
